// File: rtl/seg_scan_mux_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scanner.
package seg_scan_mux_pkg;

  localparam int unsigned MAX_DIGITS    = 8;
  localparam int unsigned BRIGHT_LEVELS = 16;

  localparam logic [6:0]            SEG_OFF   = 7'h7F;
  localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

  // Width of the sub-phase counter that runs 0..scan_div/16-1 (never narrower than 1).
  function automatic int unsigned sub_width(input int unsigned scan_div);
    int unsigned sub_len;
    sub_len = scan_div / BRIGHT_LEVELS;
    if (sub_len <= 32'd1) return 32'd1;
    return 32'($clog2(sub_len));
  endfunction

endpackage

// File: rtl/sevenseghexdecoder.sv
// Hex nibble to active-low {g,f,e,d,c,b,a} segment pattern.
module sevenseghexdecoder
  import seg_scan_mux_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG_OFF;
    case (nibble)
      4'h0: seg_c = 7'h40;
      4'h1: seg_c = 7'h79;
      4'h2: seg_c = 7'h24;
      4'h3: seg_c = 7'h30;
      4'h4: seg_c = 7'h19;
      4'h5: seg_c = 7'h12;
      4'h6: seg_c = 7'h02;
      4'h7: seg_c = 7'h78;
      4'h8: seg_c = 7'h00;
      4'h9: seg_c = 7'h10;
      4'hA: seg_c = 7'h08;
      4'hB: seg_c = 7'h03;
      4'hC: seg_c = 7'h46;
      4'hD: seg_c = 7'h21;
      4'hE: seg_c = 7'h06;
      4'hF: seg_c = 7'h0E;
      default: seg_c = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed common-anode 7-segment driver with per-slot PWM brightness.
// Leading-zero blanking is compiled in only when SEG_SCAN_LZB_EN is defined.
module seg_scan_mux
  import seg_scan_mux_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 100_000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [4*DIGITS-1:0] digits,
  input  logic [DIGITS-1:0]   dp_mask,
  input  logic [DIGITS-1:0]   blank_mask,
  input  logic [3:0]          brightness,
  output logic [DIGITS-1:0]   anode,
  output logic [6:0]          seg,
  output logic                decimal_p,
  output logic                frame_tick
);

  localparam int unsigned SUB_W   = sub_width(SCAN_DIV);
  localparam int unsigned SUB_MAX = SCAN_DIV / BRIGHT_LEVELS - 1;
  localparam int unsigned IDX_W   = $clog2(DIGITS);
  localparam logic [DIGITS-1:0] ANODE_DARK = ANODE_OFF[DIGITS-1:0];

  logic [SUB_W-1:0]  sub_q, sub_d;
  logic [3:0]        phase_q, phase_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [3:0]        slot_nib_q, slot_nib_d;
  logic [3:0]        slot_bright_q, slot_bright_d;
  logic              slot_dp_q, slot_dp_d;
  logic              slot_blank_q, slot_blank_d;
  logic              wrap_q, wrap_d;
  logic [DIGITS-1:0] anode_d;
  logic [6:0]        seg_d;
  logic              decimal_p_d, frame_tick_d;

  logic              sub_end_c, slot_end_c, slot_start_c, last_c, lit_c;
  logic [DIGITS-1:0] lzb_blank_c;
  logic [3:0]        nib_c, bright_c;
  logic              dp_c, blank_c;
  logic [6:0]        seg_c;

  assign sub_end_c    = (sub_q == SUB_W'(SUB_MAX));
  assign slot_end_c   = sub_end_c && (phase_q == 4'(BRIGHT_LEVELS - 1));
  assign slot_start_c = (sub_q == '0) && (phase_q == 4'd0);
  assign last_c       = (idx_q == IDX_W'(DIGITS - 1));

`ifdef SEG_SCAN_LZB_EN
  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin : lzb_scan
    logic upper_zero;
    lzb_blank_c = '0;
    upper_zero  = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      upper_zero     = upper_zero & (digits[4*i +: 4] == 4'h0);
      lzb_blank_c[i] = upper_zero;
    end
  end
`else
  assign lzb_blank_c = '0;
`endif

  // On the first cycle of a slot use live inputs; afterwards the latched copy.
  always_comb begin
    nib_c    = slot_nib_q;
    dp_c     = slot_dp_q;
    blank_c  = slot_blank_q;
    bright_c = slot_bright_q;
    if (slot_start_c) begin
      nib_c    = digits[{idx_q, 2'b00} +: 4];
      dp_c     = dp_mask[idx_q];
      blank_c  = blank_mask[idx_q] | lzb_blank_c[idx_q];
      bright_c = brightness;
    end
  end

  assign lit_c = ~blank_c & (phase_q <= bright_c);

  sevenseghexdecoder u_dec (
    .nibble (nib_c),
    .seg_c  (seg_c)
  );

  // Scan counters, slot latch and registered pin values.
  always_comb begin
    sub_d         = sub_q;
    phase_d       = phase_q;
    idx_d         = idx_q;
    slot_nib_d    = slot_nib_q;
    slot_bright_d = slot_bright_q;
    slot_dp_d     = slot_dp_q;
    slot_blank_d  = slot_blank_q;
    wrap_d        = 1'b0;
    anode_d       = ANODE_DARK;
    seg_d         = SEG_OFF;
    decimal_p_d   = 1'b1;
    frame_tick_d  = 1'b0;
    if (!enable) begin
      sub_d   = '0;
      phase_d = 4'd0;
      idx_d   = '0;
    end else begin
      sub_d = sub_end_c ? '0 : sub_q + SUB_W'(1);
      if (sub_end_c) phase_d = phase_q + 4'd1;
      if (slot_end_c) idx_d = last_c ? '0 : idx_q + IDX_W'(1);
      wrap_d       = slot_end_c & last_c;
      frame_tick_d = wrap_q;
      if (slot_start_c) begin
        slot_nib_d    = nib_c;
        slot_bright_d = bright_c;
        slot_dp_d     = dp_c;
        slot_blank_d  = blank_c;
      end
      if (lit_c) begin
        anode_d     = ANODE_DARK & ~(DIGITS'(1) << idx_q);
        seg_d       = seg_c;
        decimal_p_d = ~dp_c;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sub_q         <= '0;
      phase_q       <= 4'd0;
      idx_q         <= '0;
      slot_nib_q    <= 4'd0;
      slot_bright_q <= 4'd0;
      slot_dp_q     <= 1'b0;
      slot_blank_q  <= 1'b0;
      wrap_q        <= 1'b0;
      anode         <= ANODE_DARK;
      seg           <= SEG_OFF;
      decimal_p     <= 1'b1;
      frame_tick    <= 1'b0;
    end else begin
      sub_q         <= sub_d;
      phase_q       <= phase_d;
      idx_q         <= idx_d;
      slot_nib_q    <= slot_nib_d;
      slot_bright_q <= slot_bright_d;
      slot_dp_q     <= slot_dp_d;
      slot_blank_q  <= slot_blank_d;
      wrap_q        <= wrap_d;
      anode         <= anode_d;
      seg           <= seg_d;
      decimal_p     <= decimal_p_d;
      frame_tick    <= frame_tick_d;
    end
  end

endmodule
